// File: rtl/tick_recovery_pkg.sv
// Purpose: shared types and parameter-derived helpers for tick_recovery.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// state_t     : recovery FSM states.
// lo_bound    : lower edge of the accepted period window, clamped at 0.
// hi_bound    : upper edge of the accepted period window.
// timeout_cnt : counter value at which a missing edge declares loss.
package tick_recovery_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  function automatic longint unsigned lo_bound(input int unsigned nom, input int unsigned tol);
    return (nom > tol) ? 64'(nom - tol) : 64'd0;
  endfunction

  function automatic longint unsigned hi_bound(input int unsigned nom, input int unsigned tol);
    return 64'(nom) + 64'(tol);
  endfunction

  // The counter reads cnt = k-1 in the k-th cycle after a tick, so cnt hitting
  // 2*nom-1 means two full nominal periods have passed without an edge.
  function automatic longint unsigned timeout_cnt(input int unsigned nom);
    return (64'(nom) << 1) - 64'd1;
  endfunction

endpackage

// File: rtl/tick_recovery_sync_edge.sv
// Purpose: synchronize an async level into clk12Mhz and emit rise/fall pulses.
// Latency: input stable before edge k -> pulse visible after edge k+STAGES.
// Backpressure: none; pulses are one cycle wide and never held.
//
// Ports: clk12Mhz, rst_n (async active-low), din (async level),
//        rise / fall (registered one-cycle pulses, mutually exclusive).
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk12Mhz,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              s_prev;

  always_ff @(posedge clk12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      s_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], din};
      s_prev <= sync[STAGES-1];
      rise   <= sync[STAGES-1] & ~s_prev;
      fall   <= ~sync[STAGES-1] & s_prev;
    end
  end

endmodule

// File: rtl/tick_recovery.sv
// Purpose: recover a slow square wave as clock-enable ticks, measure its period, track lock.
// Latency: tick 3 cycles after slow_in rises (default); period/locked/lost 1 cycle after tick.
// Backpressure: none; all outputs are free-running status and pulses.
//
// Ports: clk12Mhz, rst_n (async active-low), slow_in (async slow wave),
//        tick / fall_tick (edge pulses), period + period_valid (rise-to-rise
//        measurement), locked / lost (registered state decodes).
module tick_recovery
  import tick_recovery_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned NOMINAL_PERIOD = 1200000,
  parameter int unsigned TOL            = 1024,
  parameter int unsigned LOCK_COUNT     = 4
) (
  input  logic             clk12Mhz,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic             tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  // Window bounds carry one extra bit so NOMINAL_PERIOD+TOL cannot overflow.
  localparam logic [CNT_W:0]     LO_BOUND    = (CNT_W+1)'(lo_bound(NOMINAL_PERIOD, TOL));
  localparam logic [CNT_W:0]     HI_BOUND    = (CNT_W+1)'(hi_bound(NOMINAL_PERIOD, TOL));
  localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(timeout_cnt(NOMINAL_PERIOD));
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam int unsigned        MATCH_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("tick_recovery: SYNC_STAGES must be at least 2");
  end
  if (NOMINAL_PERIOD < 1 || LOCK_COUNT < 1) begin : g_bad_nominal
    $error("tick_recovery: NOMINAL_PERIOD and LOCK_COUNT must be at least 1");
  end
  if ((64'(NOMINAL_PERIOD) << 1) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
    $error("tick_recovery: 2*NOMINAL_PERIOD does not fit in CNT_W bits");
  end

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk12Mhz (clk12Mhz),
    .rst_n    (rst_n),
    .din      (slow_in),
    .rise     (tick),
    .fall     (fall_tick)
  );

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     period_nx;
  logic               in_range;
  logic [MATCH_W-1:0] match;
  state_t             state;

  // cnt+1 in the tick cycle is the rise-to-rise distance in clk12Mhz cycles.
  assign period_nx = {1'b0, cnt} + 1'b1;
  assign in_range  = (period_nx >= LO_BOUND) && (period_nx <= HI_BOUND);

  always_ff @(posedge clk12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // locked/lost are assigned alongside each transition so they track the new
  // state in the same cycle the state register does.
  always_ff @(posedge clk12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (tick) begin
        // A tick always wins over a timeout landing in the same cycle.
        case (state)
          MEASURE: begin
            period       <= period_nx[CNT_W] ? CNT_MAX : period_nx[CNT_W-1:0];
            period_valid <= 1'b1;
            if (!in_range) begin
              match <= '0;
            end else if (match == MATCH_LAST) begin
              match  <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              match <= match + 1'b1;
            end
          end
          LOCKED: begin
            period       <= period_nx[CNT_W] ? CNT_MAX : period_nx[CNT_W-1:0];
            period_valid <= 1'b1;
            if (!in_range) begin
              match  <= '0;
              state  <= MEASURE;
              locked <= 1'b0;
            end
          end
          default: begin
            // IDLE or LOST: this edge only starts a fresh measurement.
            match  <= '0;
            state  <= MEASURE;
            locked <= 1'b0;
            lost   <= 1'b0;
          end
        endcase
      end else if ((state == MEASURE || state == LOCKED) && cnt == TIMEOUT_CNT) begin
        match  <= '0;
        state  <= LOST;
        locked <= 1'b0;
        lost   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_recovery.sv
// Purpose: randomized self-checking bench for tick_recovery against an edge-timing model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tick_recovery;

  localparam int NOM   = 12;
  localparam int TOLR  = 1;
  localparam int LOCKN = 3;
  localparam int CW    = 8;

  localparam int S_IDLE = 0;
  localparam int S_MEAS = 1;
  localparam int S_LOCK = 2;
  localparam int S_LOST = 3;

  logic          clk12Mhz = 1'b0;
  logic          rst_n    = 1'b0;
  logic          slow_in  = 1'b0;
  logic          tick;
  logic          fall_tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          lost;

  always #5 clk12Mhz = ~clk12Mhz;

  tick_recovery #(
    .SYNC_STAGES    (2),
    .CNT_W          (CW),
    .NOMINAL_PERIOD (NOM),
    .TOL            (TOLR),
    .LOCK_COUNT     (LOCKN)
  ) dut (
    .clk12Mhz     (clk12Mhz),
    .rst_n        (rst_n),
    .slow_in      (slow_in),
    .tick         (tick),
    .fall_tick    (fall_tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model. h[i-1] is the slow_in level seen at clock edge i since
  // reset release. An edge of slow_in first sampled at edge k appears as a
  // pulse after edge k+2. The lock tracker works on tick timestamps only.
  bit h[$];
  int e          = 0;
  int mst        = S_IDLE;
  int mmatch     = 0;
  int last_tick  = 0;
  int exp_period = 0;
  bit prev_tick  = 1'b0;

  function automatic bit hv(input int i);
    if (i < 1) return 1'b0;
    return h[i-1];
  endfunction

  function automatic bit inr(input int g);
    return (g >= NOM - TOLR) && (g <= NOM + TOLR);
  endfunction

  task automatic model_reset();
    h.delete();
    e          = 0;
    mst        = S_IDLE;
    mmatch     = 0;
    last_tick  = 0;
    exp_period = 0;
    prev_tick  = 1'b0;
  endtask

  // Drive one cycle of slow_in, then check every output just after the edge.
  task automatic step(input bit v);
    bit et;
    bit ef;
    bit epv;
    int gap;
    slow_in = v;
    @(posedge clk12Mhz);
    e++;
    h.push_back(v);
    #1;
    et  = hv(e-2) && !hv(e-3);
    ef  = !hv(e-2) && hv(e-3);
    epv = 1'b0;
    if (prev_tick) begin
      gap = (e - 1) - last_tick;
      if (mst == S_MEAS) begin
        epv        = 1'b1;
        exp_period = gap;
        if (inr(gap)) begin
          mmatch++;
          if (mmatch == LOCKN) mst = S_LOCK;
        end else begin
          mmatch = 0;
        end
      end else if (mst == S_LOCK) begin
        epv        = 1'b1;
        exp_period = gap;
        if (!inr(gap)) begin
          mst    = S_MEAS;
          mmatch = 0;
        end
      end else begin
        mst    = S_MEAS;
        mmatch = 0;
      end
      last_tick = e - 1;
    end else if ((mst == S_MEAS || mst == S_LOCK) && ((e - 1) - last_tick) == 2*NOM) begin
      mst = S_LOST;
    end
    chk("tick",         32'(tick),         32'(et));
    chk("fall_tick",    32'(fall_tick),    32'(ef));
    chk("period_valid", 32'(period_valid), 32'(epv));
    chk("period",       32'(period),       32'(exp_period));
    chk("locked",       32'(locked),       32'(mst == S_LOCK));
    chk("lost",         32'(lost),         32'(mst == S_LOST));
    prev_tick = et;
  endtask

  task automatic wave(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tick"},   32'(tick),         32'd0);
    chk({tag, "_fall"},   32'(fall_tick),    32'd0);
    chk({tag, "_pv"},     32'(period_valid), 32'd0);
    chk({tag, "_period"}, 32'(period),       32'd0);
    chk({tag, "_locked"}, 32'(locked),       32'd0);
    chk({tag, "_lost"},   32'(lost),         32'd0);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk12Mhz);
    @(negedge clk12Mhz);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int p;
    int hi;
    #2 check_all_zero("rst_init");
    @(negedge clk12Mhz);
    @(negedge clk12Mhz);
    rst_n = 1'b1;
    model_reset();

    // Nominal wave: first tick without period_valid, lock after the 4th tick.
    hold(1'b0, 4);
    for (int i = 0; i < 6; i++) wave(6, 6);
    chk("locked_after_nominal", 32'(locked), 32'd1);

    // One long period drops lock; 11/12/13 relock.
    wave(8, 8);
    wave(6, 5);
    wave(6, 6);
    wave(7, 6);
    wave(6, 6);
    wave(6, 6);
    chk("relocked", 32'(locked), 32'd1);

    // Input stalls: loss after the timeout, then recovery as a first edge.
    hold(1'b0, 40);
    chk("lost_after_stall", 32'(lost), 32'd1);
    for (int i = 0; i < 5; i++) wave(6, 6);

    // Rise arriving exactly on the timeout cycle: period 24, no loss.
    wave(12, 12);
    wave(6, 6);
    wave(6, 6);

    // Randomized periods, mostly inside the window, some long enough to time out.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) p = 11 + int'($urandom_range(0, 2));
      else                          p = int'($urandom_range(4, 30));
      hi = p / 2;
      wave(hi, p - hi);
    end

    // Reset while locked and mid-period, then restart from IDLE.
    for (int i = 0; i < 5; i++) wave(6, 6);
    chk("locked_before_reset", 32'(locked), 32'd1);
    hold(1'b1, 3);
    async_reset();
    hold(1'b1, 3);
    hold(1'b0, 6);
    for (int i = 0; i < 5; i++) wave(6, 6);
    hold(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
